// File: rtl/tff_bank_sequencer.sv
// Sequencer for a bank of T flip-flops: produces the per-bit toggle vector that counts
// up/down on a prescaled tick, loads a value in one step, and stops at a terminal count.
module tff_bank_sequencer #(
    parameter int WIDTH    = 4,
    parameter int DIV_BITS = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DIV_BITS-1:0] div_cnt;
    logic [DIV_BITS-1:0] div_next;
    logic                up_carry;
    logic                dn_borrow;

    assign tick = (state == RUN) && (&div_cnt);
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign qb   = ~q;

    // Toggle vector: bit i flips when all lower bits are ones (up) or zeros (down).
    always_comb begin
        t_vec     = '0;
        up_carry  = 1'b1;
        dn_borrow = 1'b1;
        case (state)
            RUN: begin
                if (tick && !stop) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        t_vec[i]  = dir ? up_carry : dn_borrow;
                        up_carry  = up_carry & q[i];
                        dn_borrow = dn_borrow & ~q[i];
                    end
                end
            end
            LOAD:    t_vec = q ^ load_val;
            default: t_vec = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (load)
                    state_next = LOAD;
                else if (start)
                    state_next = RUN;
            end
            LOAD: state_next = IDLE;
            RUN: begin
                if (stop)
                    state_next = IDLE;
                else if (tick && ((q ^ t_vec) == term_val))
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The prescaler only advances while staying in RUN, so it reads zero on every entry.
    always_comb begin
        div_next = '0;
        if (state == RUN && state_next == RUN)
            div_next = div_cnt + {{(DIV_BITS-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            q       <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            q       <= q ^ t_vec;
        end
    end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed bench for tff_bank_sequencer with WIDTH=4, DIV_BITS=2 (one tick per 4 clocks).
module tb_tff_bank_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] term_val;
    logic [3:0] t_vec;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tick;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       dir;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] term_val;
        logic [3:0] exp_t;
        logic [3:0] exp_q;
        logic       exp_tick;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    tff_bank_sequencer #(.WIDTH(4), .DIV_BITS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
        .load_val(load_val), .term_val(term_val), .t_vec(t_vec), .q(q), .qb(qb),
        .tick(tick), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic st, input logic sp, input logic dr, input logic ld,
                                 input logic [3:0] lv, input logic [3:0] tv, input logic [3:0] et,
                                 input logic [3:0] eq, input logic etk, input logic eb,
                                 input logic ed);
        vec_t v;
        v.start = st; v.stop = sp; v.dir = dr; v.load = ld; v.load_val = lv; v.term_val = tv;
        v.exp_t = et; v.exp_q = eq; v.exp_tick = etk; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endfunction

    task automatic apply_stimulus(input vec_t v);
        start = v.start; stop = v.stop; dir = v.dir; load = v.load;
        load_val = v.load_val; term_val = v.term_val;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check_val({tag, ".t_vec"}, t_vec, v.exp_t);
        check_val({tag, ".q"}, q, v.exp_q);
        check_val({tag, ".qb"}, qb, ~v.exp_q);
        check_val({tag, ".tick"}, {3'b0, tick}, {3'b0, v.exp_tick});
        check_val({tag, ".busy"}, {3'b0, busy}, {3'b0, v.exp_busy});
        check_val({tag, ".done"}, {3'b0, done}, {3'b0, v.exp_done});
    endtask

    // Waits (bounded) for a tick cycle and returns the toggle vector seen there.
    task automatic wait_tick(input string name, output logic [3:0] tv);
        bit seen;
        seen = 1'b0;
        tv   = 4'h0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (tick) begin
                seen = 1'b1;
                tv   = t_vec;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s tick timeout got none want tick within 16 clks", name);
        end
    endtask

    initial begin
        logic [3:0] tv;
        logic [3:0] up_t[5];

        start = 0; stop = 0; dir = 0; load = 0; load_val = 0; term_val = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_val("reset.q", q, 4'h0);
        check_val("reset.t_vec", t_vec, 4'h0);
        check_val("reset.busy", {3'b0, busy}, 4'h0);
        check_val("reset.done", {3'b0, done}, 4'h0);
        check_val("reset.tick", {3'b0, tick}, 4'h0);
        @(negedge clk);
        rst = 1'b1;

        // Idle, then load wins over start, then load back to zero.
        push(0,0,0,0, 4'h0,4'h0, 4'h0,4'h0, 0,0,0);
        push(1,0,0,1, 4'h9,4'h0, 4'h0,4'h0, 0,0,0);
        push(0,0,0,0, 4'h9,4'h0, 4'h9,4'h0, 0,0,0);
        push(0,0,0,0, 4'h9,4'h0, 4'h0,4'h9, 0,0,0);
        push(0,0,0,1, 4'h0,4'h0, 4'h0,4'h9, 0,0,0);
        push(0,0,0,0, 4'h0,4'h0, 4'h9,4'h9, 0,0,0);
        push(0,0,0,0, 4'h0,4'h0, 4'h0,4'h0, 0,0,0);
        // Up count 0..5 with term 5; load is ignored while running.
        push(1,0,1,0, 4'h0,4'h5, 4'h0,4'h0, 0,0,0);
        up_t[0] = 4'b0001; up_t[1] = 4'b0011; up_t[2] = 4'b0001;
        up_t[3] = 4'b0111; up_t[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            push(0,0,1,0, 4'h0,4'h5, 4'h0,4'(k), 0,1,0);
            push(0,0,1,(k == 1), 4'hf,4'h5, 4'h0,4'(k), 0,1,0);
            push(0,0,1,0, 4'h0,4'h5, 4'h0,4'(k), 0,1,0);
            push(0,0,1,0, 4'h0,4'h5, up_t[k],4'(k), 1,1,0);
        end
        push(0,0,1,0, 4'h0,4'h5, 4'h0,4'h5, 0,0,1);
        push(0,0,1,0, 4'h0,4'h5, 4'h0,4'h5, 0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], i);
        end

        // Down count with wrap: load 2, count down to 14.
        @(negedge clk); load = 1; load_val = 4'h2;
        @(negedge clk); load = 0;
        @(negedge clk);
        check_val("down.loaded", q, 4'h2);
        start = 1; dir = 0; term_val = 4'he;
        @(negedge clk); start = 0;
        wait_tick("down.t1", tv);
        check_val("down.t1.t_vec", tv, 4'b0011);
        @(negedge clk); check_val("down.q1", q, 4'h1);
        wait_tick("down.t2", tv);
        @(negedge clk); check_val("down.q0", q, 4'h0);
        wait_tick("down.t3", tv);
        check_val("down.wrap.t_vec", tv, 4'b1111);
        @(negedge clk); check_val("down.q15", q, 4'hf);
        check_val("down.notdone", {3'b0, done}, 4'h0);
        wait_tick("down.t4", tv);
        @(negedge clk);
        check_val("down.q14", q, 4'he);
        check_val("down.done", {3'b0, done}, 4'h1);
        check_val("down.busy", {3'b0, busy}, 4'h0);

        // Stop asserted on a tick cycle with q=6 suppresses the toggle.
        @(negedge clk); load = 1; load_val = 4'h5;
        @(negedge clk); load = 0;
        @(negedge clk); start = 1; dir = 1; term_val = 4'hf;
        @(negedge clk); start = 0;
        wait_tick("stop.t1", tv);
        @(negedge clk); check_val("stop.q6", q, 4'h6);
        wait_tick("stop.t2", tv);
        stop = 1;
        #1 check_val("stop.t_vec", t_vec, 4'h0);
        @(negedge clk); stop = 0;
        check_val("stop.q", q, 4'h6);
        check_val("stop.busy", {3'b0, busy}, 4'h0);
        check_val("stop.done", {3'b0, done}, 4'h0);

        // Terminal equal to start value: full 16-tick cycle before done.
        @(negedge clk); load = 1; load_val = 4'h0;
        @(negedge clk); load = 0;
        @(negedge clk); start = 1; dir = 1; term_val = 4'h0;
        @(negedge clk); start = 0;
        for (int k = 1; k <= 16; k++) begin
            wait_tick($sformatf("full.t%0d", k), tv);
            @(negedge clk);
            check_val($sformatf("full.q%0d", k), q, 4'(k));
            if (k == 1 || k == 15)
                check_val($sformatf("full.done%0d", k), {3'b0, done}, 4'h0);
        end
        check_val("full.done16", {3'b0, done}, 4'h1);

        // Asynchronous reset between edges while running with q=7.
        @(negedge clk); load = 1; load_val = 4'h7;
        @(negedge clk); load = 0;
        @(negedge clk); start = 1; dir = 1; term_val = 4'hc;
        @(negedge clk); start = 0;
        @(negedge clk);
        check_val("areset.pre.q", q, 4'h7);
        check_val("areset.pre.busy", {3'b0, busy}, 4'h1);
        #2 rst = 1'b0;
        #1;
        check_val("areset.q", q, 4'h0);
        check_val("areset.busy", {3'b0, busy}, 4'h0);
        check_val("areset.tick", {3'b0, tick}, 4'h0);
        check_val("areset.t_vec", t_vec, 4'h0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val($sformatf("areset.idle%0d.q", i), q, 4'h0);
            check_val($sformatf("areset.idle%0d.busy", i), {3'b0, busy}, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
